// File: rtl/parking_pkg.sv
// Shared types and default widths for the smart-parking access controller.
package parking_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StGrant,
    StLocked
  } park_state_e;

  localparam int unsigned DefTokenW = 3;
  localparam int unsigned DefTimeW  = 8;

  localparam logic [DefTimeW-1:0] DefPThreshold = 8'hF0;

endpackage

// File: rtl/parking_down_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module parking_down_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [Width-1:0] load_value_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/parking_access_controller.sv
// Token check, retry lockout, inactivity timeout and P/Q bank routing for the parking gate.
module parking_access_controller
  import parking_pkg::*;
#(
  parameter int unsigned          TOKEN_W        = DefTokenW,
  parameter int unsigned          TIME_W         = DefTimeW,
  parameter logic [TIME_W-1:0]    P_THRESHOLD    = DefPThreshold,
  parameter int unsigned          MAX_TRIES      = 3,
  parameter int unsigned          LOCK_CYCLES    = 16,
  parameter int unsigned          TIMEOUT_CYCLES = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               request,
  input  logic               confirm,
  input  logic [TOKEN_W-1:0] user_token,
  input  logic [TOKEN_W-1:0] system_token,
  input  logic [TIME_W-1:0]  time_data,
  output logic [TIME_W-1:0]  data_to_save,
  output logic               enable_P,
  output logic               enable_Q,
  output logic               granted,
  output logic               locked,
  output logic               timeout,
  output logic [3:0]         fail_count
);

  localparam int unsigned LockW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned InactW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0]        MaxTries   = 4'(MAX_TRIES);
  localparam logic [InactW-1:0] TimeoutVal = InactW'(TIMEOUT_CYCLES);
  localparam logic [LockW-1:0]  LockLoad   = LockW'(LOCK_CYCLES - 1);

  park_state_e       state_q, state_d;
  logic [InactW-1:0] inact_q, inact_d;
  logic [3:0]        fail_q, fail_d;
  logic [TIME_W-1:0] data_q, data_d;
  logic              en_p_q, en_p_d;
  logic              en_q_q, en_q_d;
  logic              timeout_q, timeout_d;
  logic              granted_q, locked_q;
  logic              lock_load, lock_dec, lock_zero;

  parking_down_counter #(
    .Width (LockW)
  ) u_lock_counter (
    .clock_i      (clock),
    .reset_ni     (reset_n),
    .load_i       (lock_load),
    .dec_i        (lock_dec),
    .load_value_i (LockLoad),
    .zero_o       (lock_zero)
  );

  assign lock_dec = (state_q == StLocked) && !lock_zero;

  always_comb begin
    state_d   = state_q;
    inact_d   = inact_q;
    fail_d    = fail_q;
    data_d    = data_q;
    en_p_d    = 1'b0;
    en_q_d    = 1'b0;
    timeout_d = 1'b0;
    lock_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        inact_d = '0;
        if (request) state_d = StActive;
      end
      StActive: begin
        // Dropping request outranks a same-edge confirm.
        if (!request) begin
          state_d = StIdle;
        end else if (confirm) begin
          inact_d = '0;
          if (user_token == system_token) begin
            state_d = StGrant;
            data_d  = time_data;
            en_p_d  = (time_data >= P_THRESHOLD);
            en_q_d  = !(time_data >= P_THRESHOLD);
            fail_d  = '0;
          end else begin
            if (fail_q < MaxTries) fail_d = fail_q + 4'd1;
            if (fail_d == MaxTries) begin
              state_d   = StLocked;
              lock_load = 1'b1;
            end
          end
        end else begin
          inact_d = inact_q + InactW'(1);
          if (inact_d == TimeoutVal) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end
        end
      end
      StGrant: begin
        if (!request) state_d = StIdle;
      end
      StLocked: begin
        if (lock_zero) begin
          state_d = StIdle;
          fail_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      inact_q   <= '0;
      fail_q    <= '0;
      data_q    <= '0;
      en_p_q    <= 1'b0;
      en_q_q    <= 1'b0;
      timeout_q <= 1'b0;
      granted_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      inact_q   <= inact_d;
      fail_q    <= fail_d;
      data_q    <= data_d;
      en_p_q    <= en_p_d;
      en_q_q    <= en_q_d;
      timeout_q <= timeout_d;
      granted_q <= (state_d == StGrant);
      locked_q  <= (state_d == StLocked);
    end
  end

  assign data_to_save = data_q;
  assign enable_P     = en_p_q;
  assign enable_Q     = en_q_q;
  assign granted      = granted_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;
  assign fail_count   = fail_q;

endmodule

// File: tb/tb_parking_access_controller.sv
// Scoreboard bench: stimulus queues expected events/snapshots, a negedge monitor checks them.
module tb_parking_access_controller;

  typedef struct packed {
    int unsigned cyc;
    logic        en_p;
    logic        en_q;
    logic        to;
    logic        lk;
    logic        gr;
    logic [7:0]  data;
    logic [3:0]  fail;
  } ev_t;

  typedef struct packed {
    logic [7:0] data;
    logic       en_p;
    logic       en_q;
    logic       gr;
    logic       lk;
    logic       to;
    logic [3:0] fail;
  } snap_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       request = 1'b0;
  logic       confirm = 1'b0;
  logic [2:0] user_token = 3'b000;
  logic [2:0] system_token = 3'b101;
  logic [7:0] time_data = 8'h00;
  logic [7:0] data_to_save;
  logic       enable_P, enable_Q, granted, locked, timeout;
  logic [3:0] fail_count;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0;
  logic        done = 1'b0;
  logic        prev_lk = 1'b0;
  logic [3:0]  prev_fail = 4'd0;
  logic [7:0]  exp_data = 8'h00;

  ev_t   sb[$];
  snap_t snap_q[$];
  string snap_name[$];

  parking_access_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .request      (request),
    .confirm      (confirm),
    .user_token   (user_token),
    .system_token (system_token),
    .time_data    (time_data),
    .data_to_save (data_to_save),
    .enable_P     (enable_P),
    .enable_Q     (enable_Q),
    .granted      (granted),
    .locked       (locked),
    .timeout      (timeout),
    .fail_count   (fail_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_ev(input int unsigned c, input logic ep, input logic eq, input logic to,
                           input logic lk, input logic gr, input logic [7:0] d,
                           input logic [3:0] f);
    sb.push_back('{cyc: c, en_p: ep, en_q: eq, to: to, lk: lk, gr: gr, data: d, fail: f});
  endtask

  task automatic expect_snap(input string name, input logic [7:0] d, input logic gr,
                             input logic lk, input logic [3:0] f);
    snap_q.push_back('{data: d, en_p: 1'b0, en_q: 1'b0, gr: gr, lk: lk, to: 1'b0, fail: f});
    snap_name.push_back(name);
  endtask

  // A confirm with the current tokens, issued for exactly one edge.
  task automatic pulse_confirm();
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
  endtask

  always @(negedge clock) begin
    ev_t   exp_ev, act_ev;
    snap_t exp_s, act_s;
    string nm;
    if (snap_q.size() != 0) begin
      exp_s = snap_q.pop_front();
      nm    = snap_name.pop_front();
      act_s = '{data: data_to_save, en_p: enable_P, en_q: enable_Q, gr: granted, lk: locked,
                to: timeout, fail: fail_count};
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL %s: got data=%h P=%b Q=%b gr=%b lk=%b to=%b fail=%0d, want data=%h P=%b Q=%b gr=%b lk=%b to=%b fail=%0d",
                 nm, act_s.data, act_s.en_p, act_s.en_q, act_s.gr, act_s.lk, act_s.to,
                 act_s.fail, exp_s.data, exp_s.en_p, exp_s.en_q, exp_s.gr, exp_s.lk,
                 exp_s.to, exp_s.fail);
      end
    end
    if (mon_en) begin
      if (enable_P || enable_Q || timeout || (locked != prev_lk) || (fail_count != prev_fail)) begin
        act_ev = '{cyc: cyc, en_p: enable_P, en_q: enable_Q, to: timeout, lk: locked,
                   gr: granted, data: data_to_save, fail: fail_count};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got cyc=%0d P=%b Q=%b to=%b lk=%b fail=%0d, want no event",
                   act_ev.cyc, act_ev.en_p, act_ev.en_q, act_ev.to, act_ev.lk, act_ev.fail);
        end else begin
          exp_ev = sb.pop_front();
          if (act_ev !== exp_ev) begin
            errors++;
            $display("FAIL event: got cyc=%0d P=%b Q=%b to=%b lk=%b gr=%b data=%h fail=%0d, want cyc=%0d P=%b Q=%b to=%b lk=%b gr=%b data=%h fail=%0d",
                     act_ev.cyc, act_ev.en_p, act_ev.en_q, act_ev.to, act_ev.lk, act_ev.gr,
                     act_ev.data, act_ev.fail, exp_ev.cyc, exp_ev.en_p, exp_ev.en_q,
                     exp_ev.to, exp_ev.lk, exp_ev.gr, exp_ev.data, exp_ev.fail);
          end
        end
      end
      prev_lk   = locked;
      prev_fail = fail_count;
    end
    if (done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL pending_events: got %0d outstanding, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick(2);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    expect_snap("reset_state", 8'h00, 1'b0, 1'b0, 4'd0);

    // Grant routed to bank P
    user_token = 3'b101; system_token = 3'b101; time_data = 8'hF3;
    request = 1'b1;
    tick();
    expect_ev(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF3, 4'd0);
    exp_data = 8'hF3;
    pulse_confirm();
    tick();
    expect_snap("grant_hold_p", exp_data, 1'b1, 1'b0, 4'd0);
    request = 1'b0;
    tick();
    expect_snap("grant_drop_p", exp_data, 1'b0, 1'b0, 4'd0);
    tick();

    // Grant routed to bank Q, just below threshold
    time_data = 8'hEF;
    request = 1'b1;
    tick();
    expect_ev(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hEF, 4'd0);
    exp_data = 8'hEF;
    pulse_confirm();
    tick();
    expect_snap("grant_hold_q", exp_data, 1'b1, 1'b0, 4'd0);
    request = 1'b0;
    tick(2);

    // Three mismatches -> 16-cycle lockout, inputs ignored while locked
    user_token = 3'b010;
    request = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      expect_ev(cyc + 1, 1'b0, 1'b0, 1'b0, (i == 3), 1'b0, exp_data, 4'(i));
      if (i == 3) expect_ev(cyc + 1 + 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_data, 4'd0);
      pulse_confirm();
      if (i < 3) tick();
    end
    user_token = 3'b101;
    for (int j = 0; j < 14; j++) begin
      request = j[0];
      confirm = ~j[0];
      tick();
    end
    request = 1'b0; confirm = 1'b0;
    tick(4);

    // Inactivity timeout, then immediate re-entry and a second timeout
    request = 1'b1;
    expect_ev(cyc + 33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_data, 4'd0);
    expect_ev(cyc + 66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_data, 4'd0);
    tick(66);
    request = 1'b0;
    tick(2);

    // fail_count survives a request drop
    user_token = 3'b010;
    request = 1'b1;
    tick();
    expect_ev(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_data, 4'd1);
    pulse_confirm();
    tick();
    expect_ev(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_data, 4'd2);
    pulse_confirm();
    request = 1'b0;
    tick(2);
    request = 1'b1;
    tick();
    expect_ev(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_data, 4'd3);
    expect_ev(cyc + 1 + 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_data, 4'd0);
    pulse_confirm();
    request = 1'b0;
    tick(18);

    // Reset in the middle of a lockout (back-to-back mismatching confirms)
    request = 1'b1;
    tick();
    expect_ev(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_data, 4'd1);
    expect_ev(cyc + 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_data, 4'd2);
    expect_ev(cyc + 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_data, 4'd3);
    confirm = 1'b1;
    tick(3);
    confirm = 1'b0;
    tick(5);
    reset_n = 1'b0; request = 1'b0;
    exp_data = 8'h00;
    expect_ev(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_data, 4'd0);
    tick();
    reset_n = 1'b1;
    expect_snap("reset_in_lock", exp_data, 1'b0, 1'b0, 4'd0);

    // Grant, then reset on the edge that ends the strobe
    user_token = 3'b101; time_data = 8'h10;
    request = 1'b1;
    tick();
    expect_ev(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 4'd0);
    pulse_confirm();
    reset_n = 1'b0;
    exp_data = 8'h00;
    tick();
    expect_snap("reset_in_grant", exp_data, 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;
    tick();

    // Normal grant after reset, exactly at threshold -> bank P
    time_data = 8'hF0;
    expect_ev(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 4'd0);
    exp_data = 8'hF0;
    pulse_confirm();
    tick();
    expect_snap("grant_after_reset", exp_data, 1'b1, 1'b0, 4'd0);
    request = 1'b0;
    tick(3);
    done = 1'b1;
  end

endmodule
